// File: rtl/inst_mem.sv
// inst_mem: instruction ROM for the fetch port, filled through a byte-serial boot-load port
module inst_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [ADDR_W:0]   ld_count
);
  typedef enum logic {IDLE, LOAD} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remain_q, remain_d, count_q, count_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              done_q, done_d;
  logic              we;
  logic [31:0]       mem_q [2**ADDR_W];
  logic              unused_addr;
  assign unused_addr = ^rom_addr_i[1:0];
  assign ld_busy  = state_q == LOAD;
  assign ld_ready = state_q == LOAD;
  assign ld_done  = done_q;
  assign ld_count = count_q;
  assign we       = state_q == LOAD && ld_valid && byte_cnt_q == 2'd3;
  // Fetch path: NOP (0) when disabled, loading, or outside the array
  always_comb begin
    rom_data_o = (!rom_ce_i || ld_busy || |rom_addr_i[31:ADDR_W+2]) ? 32'd0 : mem_q[rom_addr_i[ADDR_W+1:2]];
  end
  // Array write on the fourth byte of each word; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem_q[ptr_q] <= {asm_q, ld_byte};
  end
  // Load FSM next state: start/length capture in IDLE, byte assembly in LOAD
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    count_d    = count_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      if (ld_start) begin
        ptr_d      = ld_base;
        remain_d   = ld_len;
        byte_cnt_d = 2'd0;
        count_d    = '0;
        done_d     = ld_len == '0;
        state_d    = ld_len == '0 ? IDLE : LOAD;
      end
    end else if (ld_valid) begin
      asm_d      = {asm_q[15:0], ld_byte};
      byte_cnt_d = byte_cnt_q + 2'd1;
      if (byte_cnt_q == 2'd3) begin
        ptr_d    = ptr_q + ADDR_W'(1);
        remain_d = remain_q - (ADDR_W+1)'(1);
        count_d  = count_q + (ADDR_W+1)'(1);
        if (remain_q == (ADDR_W+1)'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end
  // Load FSM state registers; reset aborts a load and drops any partial word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      remain_q   <= '0;
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: directed bench for inst_mem with a fetch-word scoreboard
module tb_inst_mem;
  localparam int ADDR_W = 10;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rom_ce_i = 1'b0;
  logic [31:0]       rom_addr_i = '0;
  logic [31:0]       rom_data_o;
  logic              ld_start = 1'b0;
  logic [ADDR_W-1:0] ld_base = '0;
  logic [ADDR_W:0]   ld_len = '0;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_byte = '0;
  logic              ld_ready, ld_busy, ld_done;
  logic [ADDR_W:0]   ld_count;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];
  logic [31:0] wa [2];

  inst_mem #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(string tag, logic [31:0] obs);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = sb.pop_front();
      chk(tag, obs, exp);
    end
  endtask

  task automatic fetch(logic [31:0] a, output logic [31:0] d);
    rom_ce_i = 1'b1;
    rom_addr_i = a;
    #1;
    d = rom_data_o;
  endtask

  task automatic start(logic [ADDR_W-1:0] b, logic [ADDR_W:0] n);
    ld_start = 1'b1;
    ld_base = b;
    ld_len = n;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    repeat (2) @(negedge clk);
    rom_ce_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_busy", 32'(ld_busy), 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_count", 32'(ld_count), 32'd0);
    rom_ce_i = 1'b0;
    #1 chk("rst_data_ce0", rom_data_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wa[0] = 32'h34010005;
    wa[1] = 32'h24020007;
    start(0, 2);
    chk("basic_busy_rise", 32'(ld_busy), 32'd1);
    chk("basic_ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_byte = wa[i/4][31-8*(i%4) -: 8];
      if (i % 4 == 3) sb.push_back(wa[i/4]);
      chk("basic_done_low", 32'(ld_done), 32'd0);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    chk("basic_done_pulse", 32'(ld_done), 32'd1);
    chk("basic_busy_fall", 32'(ld_busy), 32'd0);
    chk("basic_count", 32'(ld_count), 32'd2);
    @(negedge clk);
    chk("basic_done_once", 32'(ld_done), 32'd0);
    fetch(32'h0, d); chk_sb("fetch_w0", d);
    fetch(32'h4, d); chk_sb("fetch_w1", d);
    fetch(32'h2, d); chk("fetch_lowbits", d, 32'h34010005);
    fetch(32'h1000, d); chk("fetch_oor", d, 32'd0);
    rom_ce_i = 1'b0;
    #1 chk("fetch_ce0", rom_data_o, 32'd0);
    @(negedge clk);
    start(5, 0);
    chk("len0_done", 32'(ld_done), 32'd1);
    chk("len0_busy", 32'(ld_busy), 32'd0);
    @(negedge clk);
    chk("len0_done_once", 32'(ld_done), 32'd0);
    chk("len0_busy_after", 32'(ld_busy), 32'd0);
    chk("len0_count", 32'(ld_count), 32'd0);
    wa[0] = 32'hA1B2C3D4;
    wa[1] = 32'h0BADF00D;
    start(10'd1023, 2);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1;
      ld_byte = wa[i/4][31-8*(i%4) -: 8];
      if (i % 4 == 3) sb.push_back(wa[i/4]);
      if (i == 3) begin
        ld_start = 1'b1;
        ld_base = 10'd100;
        ld_len = 11'd5;
      end
      @(negedge clk);
      ld_valid = 1'b0;
      ld_start = 1'b0;
      ld_byte = 8'hFF;
      if (i == 4) begin
        fetch(32'h0, d);
        chk("fetch_busy", d, 32'd0);
        rom_ce_i = 1'b0;
      end
      if (i < 7) @(negedge clk);
    end
    chk("wrap_done", 32'(ld_done), 32'd1);
    chk("wrap_count", 32'(ld_count), 32'd2);
    ld_valid = 1'b1;
    ld_byte = 8'h55;
    chk("idle_ready", 32'(ld_ready), 32'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    chk("idle_busy", 32'(ld_busy), 32'd0);
    fetch(32'hFFC, d); chk_sb("wrap_last", d);
    fetch(32'h0, d); chk_sb("wrap_first", d);
    rom_ce_i = 1'b0;
    @(negedge clk);
    wa[0] = 32'h11223344;
    wa[1] = 32'h55667788;
    start(10'd1023, 2);
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_byte = wa[i/4][31-8*(i%4) -: 8];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(ld_busy), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd0);
    chk("mid_rst_count", 32'(ld_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wa[0] = 32'hDEADBEEF;
    start(2, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_byte = wa[0][31-8*i -: 8];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    chk("reload_done", 32'(ld_done), 32'd1);
    chk("reload_count", 32'(ld_count), 32'd1);
    fetch(32'h8, d); chk("reload_word", d, 32'hDEADBEEF);
    fetch(32'hFFC, d); chk("mid_rst_kept", d, 32'h11223344);
    fetch(32'h0, d); chk("mid_rst_untouched", d, 32'h0BADF00D);
    fetch(32'h4, d); chk("basic_w1_retained", d, 32'h24020007);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_mem.md
# inst_mem

Instruction-memory responder for the five-stage MIPS core's fetch port: it answers the core's chip-enable/byte-address fetch requests with 32-bit instruction words read combinationally from a word array. A byte-serial boot-load port with a small state machine fills the array before or between program runs. The block sits outside the core, directly across the fetch interface from the PC register and the IF/ID latch.

## Interface
- ADDR_W, 10, word-address width; array depth is 2^ADDR_W words.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce_i  input  1  fetch enable from the core.
- rom_addr_i  input  32  fetch byte address (PC).
- rom_data_o  output  32  instruction word returned to the core.
- ld_start  input  1  one-cycle pulse that begins a load; sampled only in IDLE.
- ld_base  input  ADDR_W  first word address written; sampled with ld_start.
- ld_len  input  ADDR_W+1  number of words to load, 0..2^ADDR_W; sampled with ld_start.
- ld_valid  input  1  ld_byte is valid this cycle.
- ld_byte  input  8  load data byte, big-endian order (MSB byte of each word first).
- ld_ready  output  1  block accepts a byte this cycle; a byte transfers when ld_valid && ld_ready.
- ld_busy  output  1  load in progress.
- ld_done  output  1  one-cycle pulse when the load completes.
- ld_count  output  ADDR_W+1  words written by the current or most recent load.

## Operation
- Fetch path (combinational, no state):
  - rom_data_o = 0 when rom_ce_i=0, ld_busy=1, or rom_addr_i[31:ADDR_W+2] != 0.
  - Otherwise rom_data_o = mem[rom_addr_i[ADDR_W+1:2]].
  - rom_addr_i[1:0] are ignored.
  - 0 is the MIPS NOP, so a stalled or out-of-range fetch is harmless.
- Load FSM, two states, IDLE and LOAD:
  - IDLE: on ld_start=1, latch ptr=ld_base, remain=ld_len, byte_cnt=0, ld_count=0.
    - If ld_len=0, stay in IDLE and pulse ld_done next cycle.
    - Otherwise go to LOAD.
  - LOAD: ld_ready=1 and ld_busy=1.
    - Each accepted byte shifts into a 24-bit assembly register; byte_cnt increments mod 4.
    - The 4th accepted byte writes the word {asm[23:0], ld_byte} to mem[ptr] at that edge.
    - The same edge increments ptr (wraps mod 2^ADDR_W), decrements remain, and increments ld_count.
    - When that write takes remain to 0, go to IDLE and pulse ld_done next cycle.
    - ld_start in LOAD is ignored.
  - IDLE: ld_ready=0; ld_valid is ignored there.
- Array contents are not cleared by reset; they are retained across rst. A never-written word reads X in simulation.
- Only the FSM, ptr, remain, byte_cnt, assembly register, ld_count and ld_done are reset.

## Timing
- Reset values: state=IDLE, ld_ready=0, ld_busy=0, ld_done=0, ld_count=0.
  - rom_data_o then follows the fetch rule and is 0 while rom_ce_i=0.
- Reset mid-load aborts immediately and asynchronously.
  - Words already written stay written; a partial word is discarded.
  - After reset release, the block is in IDLE.
- Fetch latency is 0 cycles: data is valid in the same cycle as the address, so the core's IF/ID latch captures it at the next edge.
- Load word write latency: the word is visible on rom_data_o in the cycle after the edge that accepts its 4th byte.
- ld_busy rises in the cycle after the ld_start edge.
- ld_busy falls, and ld_done pulses high for exactly 1 cycle, in the cycle after the final write edge.
- Throughput: 1 byte per cycle maximum, so a full load takes 4*ld_len cycles plus 1.
- Gaps in ld_valid stall assembly without loss of state.
- Simultaneous write and fetch of the same word cannot occur, because fetch returns 0 while busy.
- ld_count holds its final value until the next ld_start.

## Test plan
- Reset:
  - Stimulus: drive rst=0 mid-cycle with rom_ce_i=1.
  - Response: outputs take their reset values at once; ld_ready=0.
- Basic load and fetch:
  - Stimulus: ld_start with ld_base=0, ld_len=2; bytes 34 01 00 05 24 02 00 07 back-to-back; then fetch addr 0x0 and 0x4.
  - Response: fetches return 0x34010005 and 0x24020007; ld_done pulses once, 9 cycles after ld_start; ld_count=2.
- Wrap and gaps:
  - Stimulus: ld_base=2^ADDR_W-1, ld_len=2, ld_valid toggling every other cycle.
  - Response: words land at the last index and at index 0; ld_count=2.
- Boundaries:
  - Stimulus: ld_len=0.
  - Response: ld_done pulses the next cycle and ld_busy never rises.
  - Stimulus: ld_start asserted during LOAD.
  - Response: ignored; the load completes with the original length.
- Fetch gating:
  - Stimulus: fetch during LOAD; fetch with rom_ce_i=0; fetch addr 0x00001000 with ADDR_W=10.
  - Response: all return 0x00000000.
  - Stimulus: fetch addr 0x2 after the basic load.
  - Response: returns the word at index 0.
- Reset mid-load:
  - Stimulus: assert rst after 6 bytes of a 2-word load.
  - Response: word 0 is kept and word 1 is unchanged; a new load afterwards behaves normally.
